fetch_stage: RTL and testbench

Instruction-fetch front end of the RISC-V core.
- Owns the program counter and drives it to instruction_memory, which is a combinational, byte-addressed, little-endian 32-bit read.
- Captures the returned word, together with its PC, into the IF/ID pipeline register for the decoder.
- Handles stall, branch/jump redirect, and halt detection.

---
 rtl/core_pkg.sv | 29 ++
 rtl/Cla64bit.sv | 41 ++++
 rtl/if_id_reg.sv | 64 ++++++
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared constants and helpers for the RISC-V core front end.
//   XLEN / ILEN     : address and instruction widths
//   OPCODE_HALT     : opcode field value that stops fetch
//   INSTR_NOP       : canonical NOP (addi x0, x0, 0) used for empty pipeline slots
//   IMEM_BYTES      : instruction memory size in bytes
//   fetch_act_e     : per-edge action chosen by the fetch stage
package core_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned ILEN       = 32;
    localparam logic [6:0]  OPCODE_HALT = 7'h7F;
    localparam logic [31:0] INSTR_NOP   = 32'h00000013;
    localparam int unsigned IMEM_BYTES = 1024;

    // Listed in priority order, highest first.
    typedef enum logic [2:0] {
        ActRedirect,
        ActHalted,
        ActStall,
        ActFault,
        ActHalt,
        ActFetch
    } fetch_act_e;

    function automatic logic is_halt(input logic [ILEN-1:0] instr, input logic [6:0] opcode);
        return instr[6:0] == opcode;
    endfunction

endpackage

// File: rtl/Cla64bit.sv
// Cla64bit: 64-bit carry-lookahead adder built from 4-bit lookahead groups.
//   a, b : operands
//   cin  : carry in
//   sum  : a + b + cin (mod 2^64)
//   cout : carry out of bit 63
module Cla64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);

    logic [63:0] p;
    logic [63:0] g;
    logic [64:0] c;

    always_comb begin
        p = a ^ b;
        g = a & b;
        c = '0;
        c[0] = cin;
        // Each group derives its internal carries and its carry-out from its
        // carry-in directly; only the group carries chain.
        for (int grp = 0; grp < 16; grp++) begin
            c[4*grp+1] = g[4*grp] | (p[4*grp] & c[4*grp]);
            c[4*grp+2] = g[4*grp+1] | (p[4*grp+1] & g[4*grp])
                       | (p[4*grp+1] & p[4*grp] & c[4*grp]);
            c[4*grp+3] = g[4*grp+2] | (p[4*grp+2] & g[4*grp+1])
                       | (p[4*grp+2] & p[4*grp+1] & g[4*grp])
                       | (p[4*grp+2] & p[4*grp+1] & p[4*grp] & c[4*grp]);
            c[4*grp+4] = g[4*grp+3] | (p[4*grp+3] & g[4*grp+2])
                       | (p[4*grp+3] & p[4*grp+2] & g[4*grp+1])
                       | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & g[4*grp])
                       | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & p[4*grp] & c[4*grp]);
        end
        sum  = p ^ c[63:0];
        cout = c[64];
    end

endmodule

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register (valid, pc, instr).
//   clk, reset : clock, asynchronous active-high reset to invalid/NOP
//   load       : capture pc_in/instr_in as a valid instruction
//   flush      : invalidate and replace instr with NOP (highest priority)
//   hold       : keep current contents
//   none set   : invalidate (bubble)
//   valid, pc, instr : register contents toward decode
module if_id_reg #(
    parameter int unsigned XLEN = core_pkg::XLEN
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     flush,
    input  logic                     hold,
    input  logic [XLEN-1:0]          pc_in,
    input  logic [core_pkg::ILEN-1:0] instr_in,
    output logic                     valid,
    output logic [XLEN-1:0]          pc,
    output logic [core_pkg::ILEN-1:0] instr
);

    import core_pkg::*;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [ILEN-1:0] instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush) begin
            valid_d = 1'b0;
            instr_d = INSTR_NOP;
        end else if (hold) begin
            valid_d = valid_q;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = pc_in;
            instr_d = instr_in;
        end else begin
            valid_d = 1'b0;
            instr_d = INSTR_NOP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= INSTR_NOP;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end. Owns the PC, presents it to a
// combinational instruction memory, and fills the IF/ID register.
//   clk, reset            : clock, asynchronous active-high reset
//   stall                 : hold PC and IF/ID
//   redirect_valid/target : taken branch/jump; overrides stall and halt
//   imem_pc / imem_instr  : memory address (straight from PC register) / returned word
//   if_id_valid/pc/instr  : IF/ID register toward decode
//   halted                : fetch stopped (halt opcode or fault); cleared by redirect
//   fetch_fault           : sticky, PC left the memory range
//   misalign_err          : sticky, a redirect target had low bits set
module fetch_stage #(
    parameter int unsigned          XLEN        = core_pkg::XLEN,
    parameter logic [XLEN-1:0]      RESET_PC    = '0,
    parameter int unsigned          IMEM_BYTES  = core_pkg::IMEM_BYTES,
    parameter logic [6:0]           HALT_OPCODE = core_pkg::OPCODE_HALT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    output logic [XLEN-1:0]  imem_pc,
    input  logic [31:0]      imem_instr,
    output logic             if_id_valid,
    output logic [XLEN-1:0]  if_id_pc,
    output logic [31:0]      if_id_instr,
    output logic             halted,
    output logic             fetch_fault,
    output logic             misalign_err
);

    import core_pkg::*;

    logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
    logic            halted_q, halted_d;
    logic            fault_q, fault_d;
    logic            misalign_q, misalign_d;
    logic            unused_cout;
    logic            out_of_range;
    logic            ifid_load, ifid_flush, ifid_hold;
    fetch_act_e      act;

    // Wraps modulo 2^XLEN; carry out deliberately dropped.
    Cla64bit u_pc_inc (
        .a    (pc_q),
        .b    (64'd4),
        .cin  (1'b0),
        .sum  (pc_plus4),
        .cout (unused_cout)
    );

    assign out_of_range = pc_q > XLEN'(IMEM_BYTES - 4);

    always_comb begin
        if (redirect_valid)                      act = ActRedirect;
        else if (halted_q)                       act = ActHalted;
        else if (stall)                          act = ActStall;
        else if (out_of_range)                   act = ActFault;
        else if (is_halt(imem_instr, HALT_OPCODE)) act = ActHalt;
        else                                     act = ActFetch;
    end

    always_comb begin
        pc_d       = pc_q;
        halted_d   = halted_q;
        fault_d    = fault_q;
        misalign_d = misalign_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_hold  = 1'b0;
        unique case (act)
            ActRedirect: begin
                pc_d       = {redirect_target[XLEN-1:2], 2'b00};
                misalign_d = misalign_q | (redirect_target[1:0] != 2'b00);
                halted_d   = 1'b0;
                ifid_flush = 1'b1;
            end
            ActHalted, ActStall: begin
                ifid_hold = 1'b1;
            end
            ActFault: begin
                fault_d  = 1'b1;
                halted_d = 1'b1;
            end
            ActHalt: begin
                // PC stays on the halt word; the word itself never reaches decode.
                halted_d = 1'b1;
            end
            ActFetch: begin
                pc_d      = pc_plus4;
                ifid_load = 1'b1;
            end
            default: begin
                ifid_hold = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
            misalign_q <= misalign_d;
        end
    end

    if_id_reg #(
        .XLEN (XLEN)
    ) u_if_id (
        .clk      (clk),
        .reset    (reset),
        .load     (ifid_load),
        .flush    (ifid_flush),
        .hold     (ifid_hold),
        .pc_in    (pc_q),
        .instr_in (imem_instr),
        .valid    (if_id_valid),
        .pc       (if_id_pc),
        .instr    (if_id_instr)
    );

    assign imem_pc      = pc_q;
    assign halted       = halted_q;
    assign fetch_fault  = fault_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench with a scoreboard. Each stimulus step pushes
// the expected post-edge state; a monitor pops it at the edge and compares at
// the following falling edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic [63:0] imem_pc;
    logic [31:0] imem_instr;
    logic        if_id_valid;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        halted;
    logic        fetch_fault;
    logic        misalign_err;

    typedef struct {
        int          id;
        logic [63:0] pc;
        logic        v;
        logic        chk_ipc;
        logic [63:0] ipc;
        logic [31:0] instr;
        logic        h;
        logic        f;
        logic        m;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   nstep  = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_pc         (imem_pc),
        .imem_instr      (imem_instr),
        .if_id_valid     (if_id_valid),
        .if_id_pc        (if_id_pc),
        .if_id_instr     (if_id_instr),
        .halted          (halted),
        .fetch_fault     (fetch_fault),
        .misalign_err    (misalign_err)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h0:   return 32'h00208C63;
            64'h4:   return 32'h004182B3;
            64'h8:   return 32'h000201B3;
            64'h30:  return 32'h0000007F;
            default: return 32'h00000000;
        endcase
    endfunction

    always_comb imem_instr = mem_word(imem_pc);

    function automatic void chk(input string name, input int id, input logic [63:0] got,
                                input logic [63:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL step%0d %s: got %h want %h", id, name, got, want);
    endfunction

    function automatic void chk_all(input exp_t e);
        chk("imem_pc", e.id, imem_pc, e.pc);
        chk("if_id_valid", e.id, 64'(if_id_valid), 64'(e.v));
        if (e.chk_ipc) chk("if_id_pc", e.id, if_id_pc, e.ipc);
        chk("if_id_instr", e.id, 64'(if_id_instr), 64'(e.instr));
        chk("halted", e.id, 64'(halted), 64'(e.h));
        chk("fetch_fault", e.id, 64'(fetch_fault), 64'(e.f));
        chk("misalign_err", e.id, 64'(misalign_err), 64'(e.m));
    endfunction

    function automatic exp_t mk(input logic [63:0] pc, input logic v, input logic ci,
                                input logic [63:0] ipc, input logic [31:0] instr,
                                input logic h, input logic f, input logic m);
        exp_t e;
        e.id = 0; e.pc = pc; e.v = v; e.chk_ipc = ci; e.ipc = ipc;
        e.instr = instr; e.h = h; e.f = f; e.m = m;
        return e;
    endfunction

    task automatic step(input logic s, input logic rv, input logic [63:0] tgt, input exp_t e);
        exp_t x;
        x = e;
        x.id = nstep;
        nstep++;
        stall = s;
        redirect_valid = rv;
        redirect_target = tgt;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                @(negedge clk);
                chk_all(e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        #12 reset = 1'b0;
        #1;
        chk_all(mk(64'h0, 1'b0, 1'b1, 64'h0, NOP, 1'b0, 1'b0, 1'b0));

        // Sequential fetch
        step(0, 0, 0, mk(64'h4, 1, 1, 64'h0, 32'h00208C63, 0, 0, 0));
        step(0, 0, 0, mk(64'h8, 1, 1, 64'h4, 32'h004182B3, 0, 0, 0));
        // Stall two cycles
        step(1, 0, 0, mk(64'h8, 1, 1, 64'h4, 32'h004182B3, 0, 0, 0));
        step(1, 0, 0, mk(64'h8, 1, 1, 64'h4, 32'h004182B3, 0, 0, 0));
        step(0, 0, 0, mk(64'hC, 1, 1, 64'h8, 32'h000201B3, 0, 0, 0));
        // Redirect beats stall, then halt word at 0x30
        step(1, 1, 64'h30, mk(64'h30, 0, 0, 64'h0, NOP, 0, 0, 0));
        step(0, 0, 0, mk(64'h30, 0, 0, 64'h0, NOP, 1, 0, 0));
        for (int i = 0; i < 5; i++) begin
            step(logic'(i[0]), 0, 0, mk(64'h30, 0, 0, 64'h0, NOP, 1, 0, 0));
        end
        // Misaligned redirect out of halt
        step(0, 1, 64'h1A, mk(64'h18, 0, 0, 64'h0, NOP, 0, 0, 1));
        step(0, 0, 0, mk(64'h1C, 1, 1, 64'h18, 32'h0, 0, 0, 1));
        // Out of range
        step(0, 1, 64'h400, mk(64'h400, 0, 0, 64'h0, NOP, 0, 0, 1));
        step(0, 0, 0, mk(64'h400, 0, 0, 64'h0, NOP, 1, 1, 1));
        step(0, 0, 0, mk(64'h400, 0, 0, 64'h0, NOP, 1, 1, 1));
        // Redirect clears halted but not fetch_fault; last word is in range
        step(0, 1, 64'h3FC, mk(64'h3FC, 0, 0, 64'h0, NOP, 0, 1, 1));
        step(0, 0, 0, mk(64'h400, 1, 1, 64'h3FC, 32'h0, 0, 1, 1));
        step(0, 0, 0, mk(64'h400, 0, 0, 64'h0, NOP, 1, 1, 1));
        // Redirect presented together with a halt word wins
        step(0, 1, 64'h30, mk(64'h30, 0, 0, 64'h0, NOP, 0, 1, 1));
        step(0, 1, 64'h0, mk(64'h0, 0, 0, 64'h0, NOP, 0, 1, 1));
        step(0, 0, 0, mk(64'h4, 1, 1, 64'h0, 32'h00208C63, 0, 1, 1));
        step(0, 0, 0, mk(64'h8, 1, 1, 64'h4, 32'h004182B3, 0, 1, 1));
        step(0, 0, 0, mk(64'hC, 1, 1, 64'h8, 32'h000201B3, 0, 1, 1));
        step(0, 0, 0, mk(64'h10, 1, 1, 64'hC, 32'h0, 0, 1, 1));

        // Asynchronous reset between edges
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk_all(mk(64'h0, 1'b0, 1'b1, 64'h0, NOP, 1'b0, 1'b0, 1'b0));

        total++;
        if (sb.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
